// File: rtl/pattern_history_table_pkg.sv
// Shared types and the saturating-counter rule for the gshare pattern history table.
package pht_pkg;

  typedef logic [1:0] pht_ctr_t;

  localparam pht_ctr_t SNT = 2'b00;
  localparam pht_ctr_t WNT = 2'b01;
  localparam pht_ctr_t WT  = 2'b10;
  localparam pht_ctr_t ST  = 2'b11;

  typedef enum logic {PHT_INIT, PHT_RUN} pht_state_t;

  function automatic pht_ctr_t sat_update(pht_ctr_t c, logic taken);
    if (taken) return (c == ST) ? ST : c + 2'd1;
    else       return (c == SNT) ? SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/pattern_history_table_if.sv
// Lookup/prediction and training-update bundle between the index stage and the PHT.
// Handshake: a lookup or update is taken on any rising edge where its valid and ready are
// both high; there is no backpressure beyond ready, and pred_valid pulses for one cycle.
interface pattern_history_table_if #(parameter int G_WIDTH = 7);
  import pht_pkg::*;

  logic             lookup_valid;
  logic [G_WIDTH:0] lookup_index;
  logic             pred_valid;
  logic             pred_taken;
  pht_ctr_t         pred_state;
  logic             upd_valid;
  logic [G_WIDTH:0] upd_index;
  logic             upd_taken;
  logic             ready;

  modport master (
    output lookup_valid, lookup_index, upd_valid, upd_index, upd_taken,
    input  pred_valid, pred_taken, pred_state, ready
  );

  modport slave (
    input  lookup_valid, lookup_index, upd_valid, upd_index, upd_taken,
    output pred_valid, pred_taken, pred_state, ready
  );
endinterface

// File: rtl/pattern_history_table.sv
// Gshare PHT: 2-bit counters with registered lookup, two-stage forwarded training
// pipeline and a post-reset init sweep instead of a global clear.
module pattern_history_table
  import pht_pkg::*;
#(
  parameter int       G_WIDTH    = 7,
  parameter pht_ctr_t INIT_STATE = WNT
) (
  input  logic                   clk,
  input  logic                   reset,
  pattern_history_table_if.slave bus,
  output pht_state_t             fsm_state
);

  localparam int IDX_W = G_WIDTH + 1;
  localparam int PTR_W = G_WIDTH + 2;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  pht_ctr_t mem [DEPTH];

  pht_state_t       state;
  logic [PTR_W-1:0] init_ptr;
  logic             ready_q;

  logic             u2_valid;
  logic [IDX_W-1:0] u2_index;
  logic             u2_taken;
  pht_ctr_t         u2_ctr;
  pht_ctr_t         u2_new;

  logic             pred_valid_q;
  pht_ctr_t         pred_state_q;

  logic             lookup_fire;
  logic             upd_fire;
  pht_ctr_t         lookup_rd;
  pht_ctr_t         upd_rd;

  assign lookup_fire = bus.lookup_valid && ready_q;
  assign upd_fire    = bus.upd_valid && ready_q;
  assign u2_new      = sat_update(u2_ctr, u2_taken);

  // Write-first: a read of the index U2 is writing this cycle sees U2's new value.
  always_comb begin
    lookup_rd = mem[bus.lookup_index];
    upd_rd    = mem[bus.upd_index];
    if (u2_valid && (u2_index == bus.lookup_index)) lookup_rd = u2_new;
    if (u2_valid && (u2_index == bus.upd_index))    upd_rd    = u2_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PHT_INIT;
      init_ptr     <= '0;
      ready_q      <= 1'b0;
      u2_valid     <= 1'b0;
      u2_index     <= '0;
      u2_taken     <= 1'b0;
      u2_ctr       <= SNT;
      pred_valid_q <= 1'b0;
      pred_state_q <= SNT;
    end else begin
      case (state)
        PHT_INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == PTR_LAST) begin
            state   <= PHT_RUN;
            ready_q <= 1'b1;
          end
        end
        PHT_RUN: ;
        default: state <= PHT_INIT;
      endcase

      u2_valid <= upd_fire;
      if (upd_fire) begin
        u2_index <= bus.upd_index;
        u2_taken <= bus.upd_taken;
        u2_ctr   <= upd_rd;
      end

      pred_valid_q <= lookup_fire;
      if (lookup_fire) pred_state_q <= lookup_rd;
    end
  end

  // Single write port: init sweep owns it until the table is ready, then U2 does.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == PHT_INIT) mem[init_ptr[IDX_W-1:0]] <= INIT_STATE;
      else if (u2_valid)     mem[u2_index]            <= u2_new;
    end
  end

  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_state = pred_state_q;
  assign bus.pred_taken = pred_state_q[1];
  assign bus.ready      = ready_q;
  assign fsm_state      = state;

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed and randomized checks of the PHT against an array-of-integers reference model.
module tb_pattern_history_table;
  import pht_pkg::*;

  localparam int G = 7;
  localparam int N = 1 << (G + 1);

  logic       clk = 1'b0;
  logic       reset;
  pht_state_t fsm_state;

  pattern_history_table_if #(.G_WIDTH(G)) bus ();

  pattern_history_table #(.G_WIDTH(G), .INIT_STATE(2'b01)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model and scoreboard
  int         model [N];
  int         cyc;
  logic [1:0] exp_q [$];
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    bus.lookup_valid = 1'b0;
    bus.lookup_index = '0;
    bus.upd_valid    = 1'b0;
    bus.upd_index    = '0;
    bus.upd_taken    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pred_valid", 8'(bus.pred_valid), 8'd0);
    chk("rst_pred_taken", 8'(bus.pred_taken), 8'd0);
    chk("rst_pred_state", 8'(bus.pred_state), 8'd0);
    chk("rst_ready",      8'(bus.ready),      8'd0);
    reset = 1'b0;
    cyc   = 0;
    for (int i = 0; i < N; i++) model[i] = 1;
    exp_q.delete();
  endtask

  // One clock cycle of stimulus; the model is updated at acceptance, so a lookup in the
  // same cycle sees the old value and any later access sees the new one.
  task automatic do_cycle(input logic lv, input logic [7:0] li,
                          input logic uv, input logic [7:0] ui, input logic ut);
    bit         rdy;
    logic [1:0] e;
    rdy = (cyc >= N);
    bus.lookup_valid = lv;
    bus.lookup_index = li;
    bus.upd_valid    = uv;
    bus.upd_index    = ui;
    bus.upd_taken    = ut;
    if (lv && rdy) exp_q.push_back(2'(model[li]));
    if (uv && rdy) begin
      if (ut) model[ui] = (model[ui] + 1 > 3) ? 3 : model[ui] + 1;
      else    model[ui] = (model[ui] - 1 < 0) ? 0 : model[ui] - 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("ready", 8'(bus.ready), 8'(cyc >= N));
    chk("fsm_run", 8'(fsm_state == PHT_RUN), 8'(cyc >= N));
    if (lv && rdy) begin
      e = exp_q.pop_front();
      chk("pred_valid", 8'(bus.pred_valid), 8'd1);
      chk("pred_state", 8'(bus.pred_state), 8'(e));
      chk("pred_taken", 8'(bus.pred_taken), 8'(e[1]));
    end else begin
      chk("pred_valid_idle", 8'(bus.pred_valid), 8'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic read_all();
    for (int i = 0; i < N; i++) do_cycle(1'b1, 8'(i), 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    logic [7:0] ri;
    logic [7:0] ui;
    do_reset();

    // partial sweep with traffic that must be dropped, then reset at init_ptr=100
    for (int i = 0; i < 100; i++)
      do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, N - 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)));
    do_reset();

    // full sweep; the update in the final init cycle must also be dropped
    for (int i = 0; i < N - 1; i++)
      do_cycle(1'($urandom_range(0, 1)), 8'($urandom_range(0, N - 1)),
               1'($urandom_range(0, 1)), 8'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)));
    do_cycle(1'b1, 8'h2A, 1'b1, 8'h2A, 1'b1);
    read_all();

    // four taken updates to 0x2A, observing the counter climb and saturate
    do_cycle(1'b0, 8'h00, 1'b1, 8'h2A, 1'b1);
    do_cycle(1'b1, 8'h2A, 1'b1, 8'h2A, 1'b1);
    do_cycle(1'b1, 8'h2A, 1'b1, 8'h2A, 1'b1);
    do_cycle(1'b1, 8'h2A, 1'b1, 8'h2A, 1'b1);
    do_cycle(1'b1, 8'h2A, 1'b0, 8'h00, 1'b0);

    // saturation low at 0x05
    do_cycle(1'b0, 8'h00, 1'b1, 8'h05, 1'b0);
    do_cycle(1'b1, 8'h05, 1'b1, 8'h05, 1'b0);
    do_cycle(1'b1, 8'h05, 1'b0, 8'h00, 1'b0);

    // forwarding to a lookup: same cycle sees old, next cycle sees new
    do_cycle(1'b1, 8'h10, 1'b1, 8'h10, 1'b1);
    do_cycle(1'b1, 8'h10, 1'b0, 8'h00, 1'b0);
    idle(2);

    // randomized traffic concentrated on a few indices to provoke collisions
    for (int i = 0; i < 1500; i++) begin
      ri = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, N - 1)) : 8'($urandom_range(0, 7));
      ui = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, N - 1)) : 8'($urandom_range(0, 7));
      do_cycle(1'($urandom_range(0, 1)), ri, 1'($urandom_range(0, 1)), ui, 1'($urandom_range(0, 1)));
    end
    idle(2);
    read_all();

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
